prefix_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone prefix adder/subtractor. It is the single-clock successor to the fixed 16-bit phase-clocked prefix adder.
- Generalised in width and in pipeline depth.
- Adds add/sub/carry modes, signed-overflow and zero flags, and a tag passthrough.
- Adds a valid/ready handshake with backpressure.
- Sits in the ALU datapath, feeding the result mux.

---
 rtl/prefix_adder_pkg.sv | 32 +++
 rtl/prefix_adder_pipe_level.sv | 22 ++
 rtl/prefix_adder_pipe.sv | 194 +++++++++++++++++++
 tb/tb_prefix_adder_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined prefix adder.
// Pipeline depth is derived here so the RTL and its users agree on latency.
package prefix_adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDC = 2'b01,
        OP_SUB  = 2'b10,
        OP_SUBB = 2'b11
    } op_e;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int lat(input int width, input int reg_every);
        int lv;
        lv = clog2(width);
        return 2 + (lv + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/prefix_adder_pipe_level.sv
// One combinational Kogge-Stone level: positions below SPAN pass through,
// every other position merges with the group SPAN positions below it.
module prefix_level
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SPAN  = 1
) (
    input  gp_t [WIDTH-1:0] i_gp,
    output gp_t [WIDTH-1:0] o_gp
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < SPAN) begin : g_pass
            assign o_gp[i] = i_gp[i];
        end else begin : g_black
            assign o_gp[i].g = i_gp[i].g | (i_gp[i].p & i_gp[i-SPAN].g);
            assign o_gp[i].p = i_gp[i].p & i_gp[i-SPAN].p;
        end
    end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone add/sub with valid/ready handshake and tag passthrough.
// Position 0 of the prefix vector is a virtual bit whose generate is the carry-in.
module prefix_adder_pipe
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = clog2(WIDTH);
    localparam int NSTG   = LEVELS + 1;

    logic             w_en;
    logic [WIDTH-1:0] w_bb;
    logic             w_c0;
    logic [WIDTH-1:0] w_p0;
    gp_t  [WIDTH-1:0] w_gp0;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [TAG_W-1:0] r_out_tag;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    always_comb begin
        w_bb = b;
        w_c0 = 1'b0;
        case (op_e'(op))
            OP_ADD:  begin w_bb = b;  w_c0 = 1'b0; end
            OP_ADDC: begin w_bb = b;  w_c0 = cin;  end
            OP_SUB:  begin w_bb = ~b; w_c0 = 1'b1; end
            OP_SUBB: begin w_bb = ~b; w_c0 = cin;  end
            default: begin w_bb = b;  w_c0 = 1'b0; end
        endcase
    end

    assign w_p0 = a ^ w_bb;

    // Shift up by one so the carry-in sits at position 0 with p = 0.
    always_comb begin
        w_gp0[0].g = w_c0;
        w_gp0[0].p = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            w_gp0[i].g = a[i-1] & w_bb[i-1];
            w_gp0[i].p = w_p0[i-1];
        end
    end

    gp_t  [WIDTH-1:0] w_gp   [NSTG];
    logic [WIDTH-1:0] w_p    [NSTG];
    logic             w_gmsb [NSTG];
    logic             w_vld  [NSTG];
    logic [TAG_W-1:0] w_tag  [NSTG];

    gp_t  [WIDTH-1:0] r_gp0;
    logic [WIDTH-1:0] r_p0;
    logic             r_gmsb0;
    logic             r_vld0;
    logic [TAG_W-1:0] r_tag0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld0 <= 1'b0;
        end else if (w_en) begin
            r_vld0  <= in_valid;
            r_gp0   <= w_gp0;
            r_p0    <= w_p0;
            r_gmsb0 <= a[WIDTH-1] & w_bb[WIDTH-1];
            r_tag0  <= tag;
        end
    end

    assign w_gp[0]   = r_gp0;
    assign w_p[0]    = r_p0;
    assign w_gmsb[0] = r_gmsb0;
    assign w_vld[0]  = r_vld0;
    assign w_tag[0]  = r_tag0;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        gp_t [WIDTH-1:0] w_nxt;

        prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (1 << l)
        ) u_level (
            .i_gp (w_gp[l]),
            .o_gp (w_nxt)
        );

        if (((l + 1) % REG_EVERY == 0) || (l == LEVELS - 1)) begin : g_reg
            gp_t  [WIDTH-1:0] r_gp;
            logic [WIDTH-1:0] r_p;
            logic             r_gmsb;
            logic             r_vld;
            logic [TAG_W-1:0] r_tag;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= 1'b0;
                end else if (w_en) begin
                    r_vld  <= w_vld[l];
                    r_gp   <= w_nxt;
                    r_p    <= w_p[l];
                    r_gmsb <= w_gmsb[l];
                    r_tag  <= w_tag[l];
                end
            end

            assign w_gp[l+1]   = r_gp;
            assign w_p[l+1]    = r_p;
            assign w_gmsb[l+1] = r_gmsb;
            assign w_vld[l+1]  = r_vld;
            assign w_tag[l+1]  = r_tag;
        end else begin : g_comb
            assign w_gp[l+1]   = w_nxt;
            assign w_p[l+1]    = w_p[l];
            assign w_gmsb[l+1] = w_gmsb[l];
            assign w_vld[l+1]  = w_vld[l];
            assign w_tag[l+1]  = w_tag[l];
        end
    end

    // Final group G at position i is the carry into bit i; group P is always 0.
    logic [WIDTH-1:0] w_carry;
    logic             w_unused_p;
    logic [WIDTH-1:0] w_sum;
    logic             w_cmsb;
    logic             w_cout;
    logic             w_ovf;

    always_comb begin
        w_carry    = '0;
        w_unused_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i] = w_gp[LEVELS][i].g;
            w_unused_p = w_unused_p ^ w_gp[LEVELS][i].p;
        end
    end

    assign w_sum  = w_p[LEVELS] ^ w_carry;
    assign w_cmsb = w_carry[WIDTH-1];
    assign w_cout = w_gmsb[LEVELS] | (w_p[LEVELS][WIDTH-1] & w_cmsb);
    assign w_ovf  = w_cmsb ^ w_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_en) begin
            r_out_valid <= w_vld[LEVELS];
            if (w_vld[LEVELS]) begin
                r_sum     <= w_sum;
                r_cout    <= w_cout;
                r_ovf     <= w_ovf;
                r_zero    <= ~|w_sum;
                r_out_tag <= w_tag[LEVELS];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed cases on a 16-bit instance, random
// streams with backpressure on 8-bit and 13-bit instances against an arithmetic model.
module tb_prefix_adder_pipe;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        res_t       r;
        logic [3:0] tag;
        int         acc;
        int         st;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total;
    int   bad;
    int   sel;

    logic        d_in_valid, d_in_ready, d_cin, d_out_valid, d_out_ready;
    logic        d_cout, d_ovf, d_zero;
    logic [1:0]  d_op;
    logic [15:0] d_a, d_b, d_sum;
    logic [3:0]  d_tag, d_out_tag;

    logic        s_in_valid, s_out_ready, s_cin;
    logic [1:0]  s_op;
    logic [15:0] s_a, s_b;
    logic [3:0]  s_tag;

    logic        e8_in_ready, e8_out_valid, e8_cout, e8_ovf, e8_zero;
    logic [7:0]  e8_sum;
    logic [3:0]  e8_out_tag;
    logic        e13_in_ready, e13_out_valid, e13_cout, e13_ovf, e13_zero;
    logic [12:0] e13_sum;
    logic [3:0]  e13_out_tag;

    logic        g_in_ready, g_out_valid, g_cout, g_ovf, g_zero;
    logic [15:0] g_sum;
    logic [3:0]  g_tag;

    prefix_adder_pipe #(.WIDTH(16), .REG_EVERY(1), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .op(d_op), .a(d_a), .b(d_b), .cin(d_cin), .tag(d_tag),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .sum(d_sum),
        .cout(d_cout), .ovf(d_ovf), .zero(d_zero), .out_tag(d_out_tag)
    );

    prefix_adder_pipe #(.WIDTH(8), .REG_EVERY(2), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(e8_in_ready),
        .op(s_op), .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin), .tag(s_tag),
        .out_valid(e8_out_valid), .out_ready(s_out_ready), .sum(e8_sum),
        .cout(e8_cout), .ovf(e8_ovf), .zero(e8_zero), .out_tag(e8_out_tag)
    );

    prefix_adder_pipe #(.WIDTH(13), .REG_EVERY(3), .TAG_W(4)) dut13 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(e13_in_ready),
        .op(s_op), .a(s_a[12:0]), .b(s_b[12:0]), .cin(s_cin), .tag(s_tag),
        .out_valid(e13_out_valid), .out_ready(s_out_ready), .sum(e13_sum),
        .cout(e13_cout), .ovf(e13_ovf), .zero(e13_zero), .out_tag(e13_out_tag)
    );

    always_comb begin
        if (sel == 0) begin
            g_in_ready  = e8_in_ready;
            g_out_valid = e8_out_valid;
            g_sum       = {8'h00, e8_sum};
            g_cout      = e8_cout;
            g_ovf       = e8_ovf;
            g_zero      = e8_zero;
            g_tag       = e8_out_tag;
        end else begin
            g_in_ready  = e13_in_ready;
            g_out_valid = e13_out_valid;
            g_sum       = {3'b000, e13_sum};
            g_cout      = e13_cout;
            g_ovf       = e13_ovf;
            g_zero      = e13_zero;
            g_tag       = e13_out_tag;
        end
    end

    // Plain w-bit arithmetic: a + (b or ~b) + carry-in.
    function automatic res_t model(input int w, input logic [1:0] op,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic cin);
        res_t        r;
        logic [16:0] mask, full;
        logic [15:0] aa, bb;
        logic        c0;
        mask = (17'd1 << w) - 17'd1;
        aa   = a & mask[15:0];
        bb   = (op[1] ? ~b : b) & mask[15:0];
        c0   = (op == 2'd0) ? 1'b0 : (op == 2'd2) ? 1'b1 : cin;
        full = {1'b0, aa} + {1'b0, bb} + {16'd0, c0};
        r.sum  = full[15:0] & mask[15:0];
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
        r.zero = (r.sum == 16'd0);
        return r;
    endfunction

    task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [3:0] tag,
                         output res_t obs, output logic [3:0] otag, output int lat);
        @(negedge clk);
        d_op = op; d_a = a; d_b = b; d_cin = cin; d_tag = tag;
        d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        lat = 1;
        while (!d_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!d_out_valid) lat = -1;
        obs.sum = d_sum; obs.cout = d_cout; obs.ovf = d_ovf; obs.zero = d_zero;
        otag = d_out_tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (d_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", d_out_valid); end
        total++;
        if ({d_sum, d_cout, d_ovf, d_zero, d_out_tag} !== 23'd0) begin
            bad++; $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b zero=%b tag=%h want all 0",
                            d_sum, d_cout, d_ovf, d_zero, d_out_tag);
        end
        total++;
        if (d_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", d_in_ready); end
        total++;
        if ({e8_out_valid, e13_out_valid} !== 2'b00) begin
            bad++; $display("FAIL reset_small_valid: got %b%b want 00", e8_out_valid, e13_out_valid);
        end
    endtask

    task automatic test_add();
        res_t o; logic [3:0] t; int lat;
        run16(2'd0, 16'hFFFF, 16'h0001, 1'b0, 4'h3, o, t, lat);
        total++;
        if (lat !== 6) begin bad++; $display("FAIL add_latency: got %0d want 6", lat); end
        total++;
        if ({o.sum, o.cout, o.ovf, o.zero} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL add_result: sum=%h cout=%b ovf=%b zero=%b want 0000 1 0 1", o.sum, o.cout, o.ovf, o.zero);
        end
        total++;
        if (t !== 4'h3) begin bad++; $display("FAIL add_tag: got %h want 3", t); end
    endtask

    task automatic test_sub();
        res_t o; logic [3:0] t; int lat;
        run16(2'd2, 16'h8000, 16'h0001, 1'b0, 4'h5, o, t, lat);
        total++;
        if ({o.sum, o.cout, o.ovf, o.zero} !== {16'h7FFF, 1'b1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL sub_result: sum=%h cout=%b ovf=%b zero=%b want 7fff 1 1 0", o.sum, o.cout, o.ovf, o.zero);
        end
        run16(2'd3, 16'h0005, 16'h0005, 1'b0, 4'h6, o, t, lat);
        total++;
        if ({o.sum, o.cout, o.ovf, o.zero} !== {16'hFFFF, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL subb_result: sum=%h cout=%b ovf=%b zero=%b want ffff 0 0 0", o.sum, o.cout, o.ovf, o.zero);
        end
        total++;
        if (t !== 4'h6) begin bad++; $display("FAIL subb_tag: got %h want 6", t); end
    endtask

    task automatic test_addc();
        res_t o; logic [3:0] t; int lat;
        run16(2'd1, 16'h7FFF, 16'h0000, 1'b1, 4'h7, o, t, lat);
        total++;
        if ({o.sum, o.cout, o.ovf, o.zero} !== {16'h8000, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL addc_result: sum=%h cout=%b ovf=%b zero=%b want 8000 0 1 0", o.sum, o.cout, o.ovf, o.zero);
        end
        run16(2'd0, 16'h7FFF, 16'h0000, 1'b1, 4'h8, o, t, lat);
        total++;
        if ({o.sum, o.cout, o.ovf, o.zero} !== {16'h7FFF, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL add_ignores_cin: sum=%h cout=%b ovf=%b zero=%b want 7fff 0 0 0", o.sum, o.cout, o.ovf, o.zero);
        end
    endtask

    task automatic test_back_to_back();
        res_t        er [8];
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic [1:0]  vo [8];
        logic        vc [8];
        int          nacc, nret;
        logic        exp_ir;
        logic [22:0] hold;
        nacc = 0; nret = 0; hold = '0;
        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom); vb[i] = 16'($urandom);
            vo[i] = 2'($urandom_range(0, 3)); vc[i] = 1'($urandom_range(0, 1));
            er[i] = model(16, vo[i], va[i], vb[i], vc[i]);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            d_out_ready = !(c >= 6 && c <= 8);
            d_in_valid  = (nacc < 8);
            if (nacc < 8) begin
                d_a = va[nacc]; d_b = vb[nacc]; d_op = vo[nacc]; d_cin = vc[nacc]; d_tag = 4'(nacc);
            end
            #1;
            exp_ir = !(c >= 6 && c <= 8);
            total++;
            if (d_in_ready !== exp_ir) begin
                bad++; $display("FAIL b2b_in_ready c=%0d: got %b want %b", c, d_in_ready, exp_ir);
            end
            if (c == 6) hold = {d_sum, d_cout, d_ovf, d_zero, d_out_tag};
            if (c >= 7 && c <= 9) begin
                total++;
                if ({d_out_valid, d_sum, d_cout, d_ovf, d_zero, d_out_tag} !== {1'b1, hold}) begin
                    bad++; $display("FAIL b2b_hold c=%0d: got v=%b %h want v=1 %h", c, d_out_valid,
                                    {d_sum, d_cout, d_ovf, d_zero, d_out_tag}, hold);
                end
            end
            if (d_out_valid && d_out_ready) begin
                total++;
                if (nret >= 8) begin
                    bad++; $display("FAIL b2b_extra: got tag %h want no result", d_out_tag);
                end else if ({d_out_tag, d_sum, d_cout, d_ovf, d_zero} !==
                             {4'(nret), er[nret].sum, er[nret].cout, er[nret].ovf, er[nret].zero}) begin
                    bad++; $display("FAIL b2b_result: got tag=%h sum=%h c=%b o=%b z=%b want tag=%h sum=%h c=%b o=%b z=%b",
                                    d_out_tag, d_sum, d_cout, d_ovf, d_zero, 4'(nret),
                                    er[nret].sum, er[nret].cout, er[nret].ovf, er[nret].zero);
                end
                nret++;
            end
            if (d_in_valid && d_in_ready) nacc++;
        end
        d_in_valid = 1'b0; d_out_ready = 1'b1;
        total++;
        if (nret !== 8 || nacc !== 8) begin
            bad++; $display("FAIL b2b_count: got acc=%0d ret=%0d want 8 8", nacc, nret);
        end
    endtask

    task automatic test_reset_mid();
        int          nseen, at_c;
        logic [3:0]  seen_tag;
        logic [15:0] seen_sum;
        nseen = 0; at_c = -1; seen_tag = '0; seen_sum = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            d_in_valid = 1'b1; d_out_ready = 1'b1;
            d_op = 2'($urandom_range(0, 3)); d_a = 16'($urandom); d_b = 16'($urandom);
            d_cin = 1'b1; d_tag = 4'(9 + c);
        end
        @(negedge clk);
        d_in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({d_out_valid, d_sum, d_cout, d_ovf, d_zero, d_out_tag} !== 24'd0) begin
            bad++; $display("FAIL rstmid_outputs: v=%b sum=%h c=%b o=%b z=%b tag=%h want all 0",
                            d_out_valid, d_sum, d_cout, d_ovf, d_zero, d_out_tag);
        end
        total++;
        if (d_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", d_in_ready); end
        d_in_valid = 1'b1; d_op = 2'd0; d_a = 16'h1234; d_b = 16'h1111; d_cin = 1'b0; d_tag = 4'hC;
        for (int c = 5; c < 24; c++) begin
            @(negedge clk);
            d_in_valid = 1'b0;
            #1;
            if (d_out_valid) begin
                nseen++;
                if (at_c < 0) begin at_c = c; seen_tag = d_out_tag; seen_sum = d_sum; end
            end
        end
        total++;
        if (nseen !== 1 || at_c !== 10) begin
            bad++; $display("FAIL rstmid_emerge: got %0d results first at cycle %0d want 1 at cycle 10", nseen, at_c);
        end
        total++;
        if ({seen_tag, seen_sum} !== {4'hC, 16'h2345}) begin
            bad++; $display("FAIL rstmid_result: got tag=%h sum=%h want tag=c sum=2345", seen_tag, seen_sum);
        end
    endtask

    task automatic test_random(input int s, input int w, input int L, input int nops);
        exp_t        q[$];
        exp_t        e;
        int          cyc, stalls, nacc, nret;
        logic        prev_v, prev_ret, retire;
        logic [22:0] hold;
        sel = s;
        cyc = 0; stalls = 0; nacc = 0; nret = 0;
        prev_v = 1'b0; prev_ret = 1'b0; hold = '0;
        while (nret < nops && cyc < 30000) begin
            @(negedge clk);
            s_out_ready = ($urandom_range(0, 3) != 0);
            s_in_valid  = (nacc < nops) && ($urandom_range(0, 4) != 0);
            s_a = 16'($urandom); s_b = 16'($urandom);
            s_op = 2'($urandom_range(0, 3)); s_cin = 1'($urandom_range(0, 1));
            s_tag = 4'($urandom_range(0, 15));
            #1;
            if (g_out_valid) begin
                if (prev_v && !prev_ret) begin
                    total++;
                    if ({g_sum, g_cout, g_ovf, g_zero, g_tag} !== hold) begin
                        bad++; $display("FAIL rand%0d_hold cyc=%0d: got %h want %h", w, cyc,
                                        {g_sum, g_cout, g_ovf, g_zero, g_tag}, hold);
                    end
                end else if (q.size() > 0) begin
                    total++;
                    if ((cyc - q[0].acc) != L + (stalls - q[0].st)) begin
                        bad++; $display("FAIL rand%0d_latency: got %0d want %0d", w,
                                        cyc - q[0].acc, L + (stalls - q[0].st));
                    end
                end
            end
            hold   = {g_sum, g_cout, g_ovf, g_zero, g_tag};
            retire = g_out_valid && s_out_ready;
            if (retire) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand%0d_spurious: got tag %h want no result", w, g_tag);
                end else begin
                    e = q.pop_front();
                    if ({g_tag, g_sum, g_cout, g_ovf, g_zero} !== {e.tag, e.r.sum, e.r.cout, e.r.ovf, e.r.zero}) begin
                        bad++; $display("FAIL rand%0d_result: got tag=%h sum=%h c=%b o=%b z=%b want tag=%h sum=%h c=%b o=%b z=%b",
                                        w, g_tag, g_sum, g_cout, g_ovf, g_zero,
                                        e.tag, e.r.sum, e.r.cout, e.r.ovf, e.r.zero);
                    end
                    nret++;
                end
            end
            if (s_in_valid && g_in_ready) begin
                e.r = model(w, s_op, s_a, s_b, s_cin);
                e.tag = s_tag; e.acc = cyc; e.st = stalls;
                q.push_back(e);
                nacc++;
            end
            if (!g_in_ready) stalls++;
            prev_v = g_out_valid; prev_ret = retire;
            cyc++;
        end
        s_in_valid = 1'b0; s_out_ready = 1'b1;
        total++;
        if (nret != nops || q.size() != 0) begin
            bad++; $display("FAIL rand%0d_complete: got %0d retired, %0d pending want %0d retired, 0 pending",
                            w, nret, q.size(), nops);
        end
    endtask

    initial begin
        total = 0; bad = 0; sel = 0; rst = 1'b1;
        d_in_valid = 1'b0; d_out_ready = 1'b1; d_op = 2'd0; d_a = '0; d_b = '0; d_cin = 1'b0; d_tag = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_op = 2'd0; s_a = '0; s_b = '0; s_cin = 1'b0; s_tag = '0;
        test_reset();
        test_add();
        test_sub();
        test_addc();
        test_back_to_back();
        test_reset_mid();
        test_random(0, 8, 4, 10000);
        test_random(1, 13, 4, 10000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
